// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler
//
// Purpose:
//   Sequences sprite-position updates from the physics engine into the
//   VGA_driver's sprite_row/sprite_col inputs. Position writes land in a
//   shadow bank. The shadow bank is copied into the active bank only at
//   frame end, so a sprite never tears in the middle of a scan. A one-cycle
//   frame_tick paces the physics engine. Everything runs in the clock_162
//   domain.
//
// Parameters:
//   SPRITES  number of sprites; sets the sprite_row/sprite_col array sizes
//   IDX_W    width of upd_idx, at least clog2(SPRITES) and at least 1
//
// Ports:
//   clock_162      in   pixel clock
//   rst            in   synchronous, active-high reset
//   row, col       in   raster position from the VGA_driver timing counter
//   upd_valid      in   a position write is offered
//   upd_ready      out  scheduler accepts position writes (ACCEPT state)
//   upd_idx        in   sprite index of the write
//   upd_row        in   new sprite centre row
//   upd_col        in   new sprite centre column
//   upd_commit     in   pulse: shadow bank complete, commit at next frame end
//   sprite_row     out  active rows, packed SPRITES x 11
//   sprite_col     out  active columns, packed SPRITES x 12
//   frame_tick     out  one-cycle pulse on the cycle after every frame end
//   committed      out  one-cycle pulse when the active bank was updated
//   missed_frames  out  saturating count of frame ends with no commit pending
//
// Configuration:
//   SPRITE_POS_CLAMP_EN  when defined, writes are clamped to the visible
//                        area (row <= 1199, col <= 1599) before they enter
//                        the shadow bank. When undefined, writes are stored
//                        verbatim.

module sprite_frame_scheduler #(
    parameter int SPRITES = 2,
    parameter int IDX_W   = 1
) (
    input  logic                      clock_162,
    input  logic                      rst,
    input  logic [10:0]               row,
    input  logic [11:0]               col,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [IDX_W-1:0]          upd_idx,
    input  logic [10:0]               upd_row,
    input  logic [11:0]               upd_col,
    input  logic                      upd_commit,
    output logic [SPRITES-1:0][10:0]  sprite_row,
    output logic [SPRITES-1:0][11:0]  sprite_col,
    output logic                      frame_tick,
    output logic                      committed,
    output logic [7:0]                missed_frames
);

    typedef enum logic {
        ACCEPT,
        PENDING
    } state_t;

    state_t      r_state;
    logic [10:0] r_shadowRow [SPRITES];
    logic [11:0] r_shadowCol [SPRITES];

    logic        w_frameEnd;
    logic        w_write;
    logic [10:0] w_rowIn;
    logic [11:0] w_colIn;

    // The frame end is the last pixel of the last line; the cycle after it
    // is row 0, col 0, which is blanking, so the new bank appears there.
    assign w_frameEnd = (row == 11'd1249) && (col == 12'd2159);

    // Out-of-range indices still complete the handshake; they are simply
    // never written into the shadow bank.
    assign w_write = upd_valid && upd_ready && (32'(upd_idx) < SPRITES);

`ifdef SPRITE_POS_CLAMP_EN
    // Keep stored positions inside the visible 1600x1200 area.
    assign w_rowIn = (upd_row > 11'd1199) ? 11'd1199 : upd_row;
    assign w_colIn = (upd_col > 12'd1599) ? 12'd1599 : upd_col;
`else
    // Stored verbatim; off-screen positions are left for the driver.
    assign w_rowIn = upd_row;
    assign w_colIn = upd_col;
`endif

    // Single state machine holding the shadow bank, active bank and all
    // registered outputs. In ACCEPT the shadow bank takes writes and a frame
    // end with nothing pending counts as a missed frame. A commit request
    // moves to PENDING, where writes are blocked until the next frame end
    // copies the whole shadow bank into the active bank. A commit that lands
    // on the frame end itself still waits for the following frame end.
    // The shadow bank is never cleared by a commit, so unwritten sprites keep
    // their last position.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_state       <= ACCEPT;
            upd_ready     <= 1'b1;
            frame_tick    <= 1'b0;
            committed     <= 1'b0;
            missed_frames <= 8'd0;
            sprite_row    <= '0;
            sprite_col    <= '0;
            for (int i = 0; i < SPRITES; i++) begin
                r_shadowRow[i] <= 11'd0;
                r_shadowCol[i] <= 12'd0;
            end
        end else begin
            frame_tick <= w_frameEnd;
            committed  <= 1'b0;
            case (r_state)
                ACCEPT: begin
                    if (w_write) begin
                        r_shadowRow[upd_idx] <= w_rowIn;
                        r_shadowCol[upd_idx] <= w_colIn;
                    end
                    if (w_frameEnd && (missed_frames != 8'hFF)) begin
                        missed_frames <= missed_frames + 8'd1;
                    end
                    if (upd_commit) begin
                        r_state   <= PENDING;
                        upd_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (w_frameEnd) begin
                        for (int i = 0; i < SPRITES; i++) begin
                            sprite_row[i] <= r_shadowRow[i];
                            sprite_col[i] <= r_shadowCol[i];
                        end
                        committed <= 1'b1;
                        r_state   <= ACCEPT;
                        upd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ACCEPT;
                    upd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler
//
// Purpose:
//   Directed testbench for sprite_frame_scheduler. The bench drives the
//   raster row/col directly, so a frame end is produced by presenting
//   row 1249 / col 2159 for one cycle instead of scanning a whole frame.
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   at the same point, away from the active edge.
//
// Configuration:
//   SPRITE_POS_CLAMP_EN  selects the clamped or verbatim expectation in
//                        test_position_store.

module tb_sprite_frame_scheduler;

    logic             clock_162;
    logic             rst;
    logic [10:0]      row;
    logic [11:0]      col;
    logic             upd_valid;
    logic             upd_ready;
    logic [0:0]       upd_idx;
    logic [10:0]      upd_row;
    logic [11:0]      upd_col;
    logic             upd_commit;
    logic [1:0][10:0] sprite_row;
    logic [1:0][11:0] sprite_col;
    logic             frame_tick;
    logic             committed;
    logic [7:0]       missed_frames;

    int checks = 0;
    int fails  = 0;

    sprite_frame_scheduler #(
        .SPRITES(2),
        .IDX_W  (1)
    ) dut (
        .clock_162    (clock_162),
        .rst          (rst),
        .row          (row),
        .col          (col),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_idx      (upd_idx),
        .upd_row      (upd_row),
        .upd_col      (upd_col),
        .upd_commit   (upd_commit),
        .sprite_row   (sprite_row),
        .sprite_col   (sprite_col),
        .frame_tick   (frame_tick),
        .committed    (committed),
        .missed_frames(missed_frames)
    );

    // Free-running pixel clock.
    initial begin
        clock_162 = 1'b0;
        forever #3 clock_162 = ~clock_162;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock_162);
        #1;
    endtask

    // Present a single frame-end cycle, then return the raster mid-frame.
    task automatic doFe();
        row = 11'd1249;
        col = 12'd2159;
        tick();
        row = 11'd500;
        col = 12'd0;
    endtask

    // Offer one position write for a single cycle, optionally with commit.
    task automatic applyStimulus(input logic [0:0] idx, input logic [10:0] r,
                                 input logic [11:0] c, input logic cmt);
        upd_valid  = 1'b1;
        upd_idx    = idx;
        upd_row    = r;
        upd_col    = c;
        upd_commit = cmt;
        tick();
        upd_valid  = 1'b0;
        upd_commit = 1'b0;
    endtask

    // Hold reset for two cycles then release it.
    task automatic pulseReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulseReset();
        checks++;
        if (upd_ready !== 1'b1) begin
            $display("[TB] FAIL reset_ready: got %0b want 1", upd_ready); fails++;
        end
        checks++;
        if (frame_tick !== 1'b0 || committed !== 1'b0) begin
            $display("[TB] FAIL reset_pulses: got tick=%0b commit=%0b want 0/0", frame_tick, committed); fails++;
        end
        checks++;
        if (missed_frames !== 8'd0) begin
            $display("[TB] FAIL reset_missed: got %0d want 0", missed_frames); fails++;
        end
        checks++;
        if (sprite_row !== 22'd0 || sprite_col !== 24'd0) begin
            $display("[TB] FAIL reset_active: got row=%h col=%h want 0/0", sprite_row, sprite_col); fails++;
        end
    endtask

    task automatic test_idle_frame();
        tick();
        doFe();
        checks++;
        if (frame_tick !== 1'b1) begin
            $display("[TB] FAIL idle_tick: got %0b want 1", frame_tick); fails++;
        end
        checks++;
        if (missed_frames !== 8'd1) begin
            $display("[TB] FAIL idle_missed: got %0d want 1", missed_frames); fails++;
        end
        checks++;
        if (committed !== 1'b0 || sprite_row !== 22'd0 || sprite_col !== 24'd0) begin
            $display("[TB] FAIL idle_active: got commit=%0b row=%h col=%h want 0/0/0", committed, sprite_row, sprite_col); fails++;
        end
        tick();
        checks++;
        if (frame_tick !== 1'b0) begin
            $display("[TB] FAIL idle_tick_off: got %0b want 0", frame_tick); fails++;
        end
    endtask

    task automatic test_commit();
        applyStimulus(1'b0, 11'd600, 12'd800, 1'b0);
        applyStimulus(1'b1, 11'd100, 12'd200, 1'b0);
        upd_commit = 1'b1;
        tick();
        upd_commit = 1'b0;
        checks++;
        if (upd_ready !== 1'b0) begin
            $display("[TB] FAIL commit_ready_low: got %0b want 0", upd_ready); fails++;
        end
        tick();
        tick();
        checks++;
        if (sprite_row !== 22'd0 || sprite_col !== 24'd0) begin
            $display("[TB] FAIL commit_early: got row=%h col=%h want 0/0", sprite_row, sprite_col); fails++;
        end
        doFe();
        checks++;
        if (sprite_row !== {11'd100, 11'd600} || sprite_col !== {12'd200, 12'd800}) begin
            $display("[TB] FAIL commit_active: got row=%h col=%h want %h/%h", sprite_row, sprite_col,
                     {11'd100, 11'd600}, {12'd200, 12'd800}); fails++;
        end
        checks++;
        if (committed !== 1'b1 || frame_tick !== 1'b1) begin
            $display("[TB] FAIL commit_pulses: got commit=%0b tick=%0b want 1/1", committed, frame_tick); fails++;
        end
        checks++;
        if (missed_frames !== 8'd1 || upd_ready !== 1'b1) begin
            $display("[TB] FAIL commit_missed_ready: got missed=%0d ready=%0b want 1/1", missed_frames, upd_ready); fails++;
        end
        tick();
        checks++;
        if (committed !== 1'b0) begin
            $display("[TB] FAIL commit_pulse_off: got %0b want 0", committed); fails++;
        end
    endtask

    task automatic test_same_cycle_write();
        applyStimulus(1'b0, 11'd10, 12'd10, 1'b1);
        upd_valid = 1'b1;
        upd_idx   = 1'b0;
        upd_row   = 11'd77;
        upd_col   = 12'd77;
        checks++;
        if (upd_ready !== 1'b0) begin
            $display("[TB] FAIL samecycle_ready: got %0b want 0", upd_ready); fails++;
        end
        tick();
        tick();
        upd_valid = 1'b0;
        doFe();
        checks++;
        if (sprite_row !== {11'd100, 11'd10} || sprite_col !== {12'd200, 12'd10}) begin
            $display("[TB] FAIL samecycle_active: got row=%h col=%h want %h/%h", sprite_row, sprite_col,
                     {11'd100, 11'd10}, {12'd200, 12'd10}); fails++;
        end
        checks++;
        if (committed !== 1'b1) begin
            $display("[TB] FAIL samecycle_commit: got %0b want 1", committed); fails++;
        end
    endtask

    task automatic test_commit_on_fe();
        applyStimulus(1'b1, 11'd300, 12'd400, 1'b0);
        row        = 11'd1249;
        col        = 12'd2159;
        upd_commit = 1'b1;
        tick();
        upd_commit = 1'b0;
        row        = 11'd500;
        col        = 12'd0;
        checks++;
        if (missed_frames !== 8'd2) begin
            $display("[TB] FAIL cmtfe_missed: got %0d want 2", missed_frames); fails++;
        end
        checks++;
        if (committed !== 1'b0 || frame_tick !== 1'b1 || upd_ready !== 1'b0) begin
            $display("[TB] FAIL cmtfe_flags: got commit=%0b tick=%0b ready=%0b want 0/1/0", committed, frame_tick, upd_ready); fails++;
        end
        checks++;
        if (sprite_row !== {11'd100, 11'd10} || sprite_col !== {12'd200, 12'd10}) begin
            $display("[TB] FAIL cmtfe_hold: got row=%h col=%h want %h/%h", sprite_row, sprite_col,
                     {11'd100, 11'd10}, {12'd200, 12'd10}); fails++;
        end
        tick();
        doFe();
        checks++;
        if (sprite_row !== {11'd300, 11'd10} || sprite_col !== {12'd400, 12'd10} || committed !== 1'b1) begin
            $display("[TB] FAIL cmtfe_land: got row=%h col=%h commit=%0b want %h/%h/1", sprite_row, sprite_col, committed,
                     {11'd300, 11'd10}, {12'd400, 12'd10}); fails++;
        end
        checks++;
        if (missed_frames !== 8'd2) begin
            $display("[TB] FAIL cmtfe_missed_after: got %0d want 2", missed_frames); fails++;
        end
    endtask

    task automatic test_reset_pending();
        applyStimulus(1'b0, 11'd50, 12'd50, 1'b1);
        checks++;
        if (upd_ready !== 1'b0) begin
            $display("[TB] FAIL rstpend_ready_low: got %0b want 0", upd_ready); fails++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        doFe();
        checks++;
        if (committed !== 1'b0 || sprite_row !== 22'd0 || sprite_col !== 24'd0) begin
            $display("[TB] FAIL rstpend_active: got commit=%0b row=%h col=%h want 0/0/0", committed, sprite_row, sprite_col); fails++;
        end
        checks++;
        if (upd_ready !== 1'b1 || missed_frames !== 8'd1) begin
            $display("[TB] FAIL rstpend_state: got ready=%0b missed=%0d want 1/1", upd_ready, missed_frames); fails++;
        end
    endtask

    task automatic test_shadow_persist();
        applyStimulus(1'b1, 11'd7, 12'd8, 1'b1);
        doFe();
        checks++;
        if (sprite_row !== {11'd7, 11'd0} || sprite_col !== {12'd8, 12'd0}) begin
            $display("[TB] FAIL persist_first: got row=%h col=%h want %h/%h", sprite_row, sprite_col,
                     {11'd7, 11'd0}, {12'd8, 12'd0}); fails++;
        end
        tick();
        doFe();
        checks++;
        if (sprite_row !== {11'd7, 11'd0} || committed !== 1'b0 || missed_frames !== 8'd2) begin
            $display("[TB] FAIL persist_idle: got row=%h commit=%0b missed=%0d want %h/0/2", sprite_row, committed,
                     missed_frames, {11'd7, 11'd0}); fails++;
        end
        applyStimulus(1'b0, 11'd9, 12'd9, 1'b1);
        doFe();
        checks++;
        if (sprite_row !== {11'd7, 11'd9} || sprite_col !== {12'd8, 12'd9}) begin
            $display("[TB] FAIL persist_second: got row=%h col=%h want %h/%h", sprite_row, sprite_col,
                     {11'd7, 11'd9}, {12'd8, 12'd9}); fails++;
        end
    endtask

    task automatic test_saturation();
        pulseReset();
        for (int i = 0; i < 254; i++) begin
            doFe();
        end
        checks++;
        if (missed_frames !== 8'd254) begin
            $display("[TB] FAIL sat_254: got %0d want 254", missed_frames); fails++;
        end
        doFe();
        checks++;
        if (missed_frames !== 8'd255) begin
            $display("[TB] FAIL sat_255: got %0d want 255", missed_frames); fails++;
        end
        for (int i = 0; i < 45; i++) begin
            doFe();
        end
        checks++;
        if (missed_frames !== 8'd255 || frame_tick !== 1'b1) begin
            $display("[TB] FAIL sat_hold: got missed=%0d tick=%0b want 255/1", missed_frames, frame_tick); fails++;
        end
    endtask

    task automatic test_position_store();
        logic [10:0] expRow;
        logic [11:0] expCol;
`ifdef SPRITE_POS_CLAMP_EN
        expRow = 11'd1199;
        expCol = 12'd1599;
`else
        expRow = 11'd1210;
        expCol = 12'd1700;
`endif
        tick();
        applyStimulus(1'b0, 11'd1210, 12'd1700, 1'b1);
        doFe();
        checks++;
        if (sprite_row[0] !== expRow || sprite_col[0] !== expCol) begin
            $display("[TB] FAIL store_value: got row=%0d col=%0d want %0d/%0d", sprite_row[0], sprite_col[0], expRow, expCol); fails++;
        end
    endtask

    // Scenario sequence; each test leaves the DUT in ACCEPT for the next.
    initial begin
        rst        = 1'b1;
        row        = 11'd500;
        col        = 12'd0;
        upd_valid  = 1'b0;
        upd_idx    = 1'b0;
        upd_row    = 11'd0;
        upd_col    = 12'd0;
        upd_commit = 1'b0;

        test_reset();
        test_idle_frame();
        test_commit();
        test_same_cycle_write();
        test_commit_on_fe();
        test_reset_pending();
        test_shadow_persist();
        test_saturation();
        test_position_store();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
